// File: rtl/sub_diff_accum_pkg.sv
// Shared types and defaults for the dual difference accumulator.
// FSM encodings plus default widths used by sub_diff_accum and sub_acc_add.
package sub_diff_accum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int DEF_DIFF_W    = 5;
  localparam int DEF_ACC_W     = 7;
  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_CNT_W     = 3;

endpackage

// File: rtl/sub_acc_add.sv
// Sign-extending accumulator adder with overflow detect.
// Optional clamp on overflow when SUB_ACC_SAT_EN is defined.
module sub_acc_add
  import sub_diff_accum_pkg::*;
#(
  parameter int DIFF_W = DEF_DIFF_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [DIFF_W-1:0] d,
  output logic [ACC_W-1:0]  res,
  output logic              ovf
);

  logic [ACC_W:0] wide;

  // One guard bit: the two MSBs disagree exactly when ACC_W range is left.
  assign wide = {acc[ACC_W-1], acc}
              + {{(ACC_W+1-DIFF_W){d[DIFF_W-1]}}, d};
  assign ovf  = wide[ACC_W] ^ wide[ACC_W-1];

`ifdef SUB_ACC_SAT_EN
  localparam logic [ACC_W-1:0] MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // Clamp toward the sign of the true (guard-bit) result.
  always_comb begin
    res = wide[ACC_W-1:0];
    if (ovf) res = wide[ACC_W] ? MIN : MAX;
  end
`else
  assign res = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/sub_diff_accum.sv
// Frame accumulator for the dual subtractor's s1/s2 differences.
// Build option: SUB_ACC_SAT_EN selects saturating instead of wrapping sums.
module sub_diff_accum
  import sub_diff_accum_pkg::*;
#(
  parameter int DIFF_W    = DEF_DIFF_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIFF_W-1:0] s1,
  input  logic [DIFF_W-1:0] s2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  sum1,
  output logic [ACC_W-1:0]  sum2,
  output logic              ovf1,
  output logic              ovf2,
  output logic [CNT_W-1:0]  cnt
);

  if (FRAME_LEN < 2) begin : g_bad_len
    $error("FRAME_LEN must be at least 2");
  end
  if ((2 ** CNT_W) < FRAME_LEN) begin : g_bad_cnt
    $error("CNT_W too narrow for FRAME_LEN");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state;
  logic             accept;
  logic [ACC_W-1:0] base1, base2;
  logic [ACC_W-1:0] nxt1, nxt2;
  logic             o1, o2;

  assign accept = in_valid & in_ready;

  // A new frame starts from zero, so the first pair is a plain sign extension.
  assign base1 = (state == ST_IDLE) ? '0 : sum1;
  assign base2 = (state == ST_IDLE) ? '0 : sum2;

  sub_acc_add #(.DIFF_W(DIFF_W), .ACC_W(ACC_W)) u_add1 (
    .acc (base1),
    .d   (s1),
    .res (nxt1),
    .ovf (o1)
  );

  sub_acc_add #(.DIFF_W(DIFF_W), .ACC_W(ACC_W)) u_add2 (
    .acc (base2),
    .d   (s2),
    .res (nxt2),
    .ovf (o2)
  );

  // Frame FSM with registered handshake outputs, sums and sticky flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      sum1      <= '0;
      sum2      <= '0;
      ovf1      <= 1'b0;
      ovf2      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (clr) begin
      state     <= ST_IDLE;
      sum1      <= '0;
      sum2      <= '0;
      ovf1      <= 1'b0;
      ovf2      <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sum1  <= nxt1;
            sum2  <= nxt2;
            ovf1  <= o1;
            ovf2  <= o2;
            cnt   <= CNT_W'(1);
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            sum1 <= nxt1;
            sum2 <= nxt2;
            ovf1 <= ovf1 | o1;
            ovf2 <= ovf2 | o2;
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
              state     <= ST_HOLD;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            sum1      <= '0;
            sum2      <= '0;
            ovf1      <= 1'b0;
            ovf2      <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_diff_accum.sv
// Directed self-checking bench for sub_diff_accum.
// Expected sums follow SUB_ACC_SAT_EN when the bench is built with it.
module tb_sub_diff_accum;

  logic       clk;
  logic       reset;
  logic       clr;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] s1;
  logic [4:0] s2;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] sum1;
  logic [6:0] sum2;
  logic       ovf1;
  logic       ovf2;
  logic [2:0] cnt;

  int errors = 0;
  int checks = 0;

  sub_diff_accum dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s1        (s1),
    .s2        (s2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum1      (sum1),
    .sum2      (sum2),
    .ovf1      (ovf1),
    .ovf2      (ovf2),
    .cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int n, input int a, input int b);
    in_valid = 1'b1;
    s1 = 5'(a);
    s2 = 5'(b);
    for (int i = 0; i < n; i++) tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ($signed(sum1) !== 0 || $signed(sum2) !== 0) begin
      errors++;
      $display("FAIL reset_sums got %0d %0d want 0 0",
               $signed(sum1), $signed(sum2));
    end
    checks++;
    if ({ovf1, ovf2, out_valid, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_flags got %b want 0001",
               {ovf1, ovf2, out_valid, in_ready});
    end
    checks++;
    if (cnt !== 3'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d want 0", cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    feed(4, 2, 1);
    checks++;
    if (cnt !== 3'd4 || $signed(sum1) !== 8) begin
      errors++;
      $display("FAIL mid_pre got cnt=%0d sum1=%0d want 4 8",
               cnt, $signed(sum1));
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ($signed(sum1) !== 0 || $signed(sum2) !== 0 || cnt !== 3'd0) begin
      errors++;
      $display("FAIL mid_rst got %0d %0d cnt=%0d want 0 0 0",
               $signed(sum1), $signed(sum2), cnt);
    end
    checks++;
    if ({ovf1, ovf2, out_valid, in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL mid_rst_flags got %b want 0001",
               {ovf1, ovf2, out_valid, in_ready});
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_frame();
    feed(7, 3, -2);
    in_valid = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || cnt !== 3'd7) begin
      errors++;
      $display("FAIL frame_7 got ov=%b cnt=%0d want 0 7", out_valid, cnt);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || cnt !== 3'd0) begin
      errors++;
      $display("FAIL frame_8 got ov=%b ir=%b cnt=%0d want 1 0 0",
               out_valid, in_ready, cnt);
    end
    checks++;
    if ($signed(sum1) !== 24 || $signed(sum2) !== -16) begin
      errors++;
      $display("FAIL frame_sums got %0d %0d want 24 -16",
               $signed(sum1), $signed(sum2));
    end
    checks++;
    if (ovf1 !== 1'b0 || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL frame_ovf got %b%b want 00", ovf1, ovf2);
    end
  endtask

  task automatic test_hold();
    out_ready = 1'b0;
    in_valid = 1'b1;
    s1 = 5'd7;
    s2 = 5'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_hs%0d got ov=%b ir=%b want 1 0",
                 i, out_valid, in_ready);
      end
      checks++;
      if ($signed(sum1) !== 24 || $signed(sum2) !== -16) begin
        errors++;
        $display("FAIL hold_sums%0d got %0d %0d want 24 -16",
                 i, $signed(sum1), $signed(sum2));
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handoff got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
    checks++;
    if ($signed(sum1) !== 0 || $signed(sum2) !== 0 || cnt !== 3'd0) begin
      errors++;
      $display("FAIL handoff_clr got %0d %0d cnt=%0d want 0 0 0",
               $signed(sum1), $signed(sum2), cnt);
    end
  endtask

  task automatic test_overflow();
    int e1;
    int e2;
`ifdef SUB_ACC_SAT_EN
    e1 = 63;
    e2 = -64;
`else
    e1 = -8;
    e2 = 8;
`endif
    feed(8, 15, -15);
    checks++;
    if ($signed(sum1) !== e1 || $signed(sum2) !== e2) begin
      errors++;
      $display("FAIL ovf_sums got %0d %0d want %0d %0d",
               $signed(sum1), $signed(sum2), e1, e2);
    end
    checks++;
    if (ovf1 !== 1'b1 || ovf2 !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flags got %b%b%b want 111", ovf1, ovf2, out_valid);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (ovf1 !== 1'b0 || ovf2 !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b%b want 00", ovf1, ovf2);
    end
  endtask

  task automatic test_gaps();
    int acc_n;
    acc_n = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      s1 = (i % 2 == 0) ? 5'(i) : 5'(-i);
      s2 = (i % 2 == 0) ? 5'(-i) : 5'(i);
      tick();
      if (i % 2 == 0) acc_n++;
      if (i < 15) begin
        checks++;
        if (cnt !== 3'(acc_n)) begin
          errors++;
          $display("FAIL gap_cnt%0d got %0d want %0d", i, cnt, acc_n);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || cnt !== 3'd0) begin
      errors++;
      $display("FAIL gap_done got ov=%b cnt=%0d want 1 0", out_valid, cnt);
    end
    checks++;
    if ($signed(sum1) !== 56 || $signed(sum2) !== -56) begin
      errors++;
      $display("FAIL gap_sums got %0d %0d want 56 -56",
               $signed(sum1), $signed(sum2));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_clr_back_to_back();
    feed(5, 4, -3);
    checks++;
    if (cnt !== 3'd5 || $signed(sum1) !== 20) begin
      errors++;
      $display("FAIL clr_pre got cnt=%0d sum1=%0d want 5 20",
               cnt, $signed(sum1));
    end
    clr = 1'b1;
    in_valid = 1'b1;
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (cnt !== 3'd0 || $signed(sum1) !== 0 || $signed(sum2) !== 0) begin
      errors++;
      $display("FAIL clr got cnt=%0d %0d %0d want 0 0 0",
               cnt, $signed(sum1), $signed(sum2));
    end
    feed(8, 1, 2);
    checks++;
    if (out_valid !== 1'b1 || $signed(sum1) !== 8 || $signed(sum2) !== 16) begin
      errors++;
      $display("FAIL b2b_f1 got ov=%b %0d %0d want 1 8 16",
               out_valid, $signed(sum1), $signed(sum2));
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    s1 = 5'd5;
    s2 = 5'd1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready got ir=%b ov=%b want 1 0", in_ready, out_valid);
    end
    feed(8, 5, 1);
    checks++;
    if (out_valid !== 1'b1 || $signed(sum1) !== 40 || $signed(sum2) !== 8) begin
      errors++;
      $display("FAIL b2b_f2 got ov=%b %0d %0d want 1 40 8",
               out_valid, $signed(sum1), $signed(sum2));
    end
    clr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || $signed(sum1) !== 0) begin
      errors++;
      $display("FAIL clr_hold got ov=%b ir=%b sum1=%0d want 0 1 0",
               out_valid, in_ready, $signed(sum1));
    end
  endtask

  initial begin
    reset = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    s1 = '0;
    s2 = '0;
    #2;
    test_reset();
    test_reset_mid();
    test_frame();
    test_hold();
    test_overflow();
    test_gaps();
    test_clr_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
